tournament_chooser: RTL
=======================

# tournament_chooser

Parametrised choice (meta) predictor for the tournament branch predictor: a table of 2^IDX_W saturating counters, indexed by path history, that selects between the local and global predictors. Lookups are pipelined with one cycle of latency. Training happens on a separate resolve-time update port and only when the two component predictors disagree. After reset, a sweep FSM initialises the table one entry per cycle, so the array can map to single-port-write RAM.

## Interface
- IDX_W, 12, index width; table depth = 2^IDX_W
- CTR_W, 2, counter width (>=2)
- INIT_VAL, 2^(CTR_W-1), counter value written by the init sweep (weakly-global)
- clock  input  1  clock
- reset  input  1  reset, synchronous, active-high
- lookup_valid  input  1  lookup request this cycle
- lookup_idx  input  IDX_W  path-history index for the lookup
- upd_valid  input  1  resolved-branch training request
- upd_idx  input  IDX_W  index used when the branch was predicted
- upd_local_correct  input  1  local predictor was correct
- upd_global_correct  input  1  global predictor was correct
- ready  output  1  init sweep complete; table usable
- choice_valid  output  1  choice_use_global is valid this cycle
- choice_use_global  output  1  1 = use global prediction (counter MSB set)

## Operation
- FSM states are INIT and RUN. Reset sends the FSM to INIT and zeroes the sweep pointer.
- INIT: each cycle, write INIT_VAL to entry[ptr] and increment ptr. After writing entry 2^IDX_W-1, go to RUN.
- In INIT, lookups and updates are dropped and produce no choice_valid.
- RUN: ready=1.
- Lookup: choice_valid and choice_use_global are registered from lookup_valid and from MSB of entry[lookup_idx].
- Update: applies only when upd_valid=1 and upd_local_correct != upd_global_correct.
  - Global correct: counter +1, saturating at 2^CTR_W-1.
  - Local correct: counter -1, saturating at 0.
  - Agreement (both correct or both wrong): no write.
- Update and lookup in the same cycle to the same index: the lookup result reflects the post-update counter (write-first bypass).
- Arithmetic is CTR_W bits unsigned. The counter never wraps.
- Reset values: ready=0, choice_valid=0, choice_use_global=0.

## Timing
- Lookup latency is 1 cycle. A lookup presented at edge N gives choice_valid at N+1. The result is held for only that one cycle.
- Back-to-back lookups are sustained at 1 per cycle. There is no backpressure.
- Updates take effect at the next edge. A lookup to the same index one cycle later sees the new value.
- Init sweep takes exactly 2^IDX_W cycles after reset deasserts. ready rises on the edge after the last entry is written.
- Reset asserted mid-RUN or mid-INIT:
  - choice_valid clears the following cycle.
  - The sweep restarts from entry 0.
  - A lookup in flight at reset is discarded.

## Configuration
- CHOOSER_STATS_EN defined: adds two 32-bit outputs.
  - stat_train: count of applied (disagreeing) updates.
  - stat_flip: count of updates that changed a counter MSB.
  - Both counters clear on reset, saturate at all-ones, and do not count during INIT.
- CHOOSER_STATS_EN undefined: the ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- tournament_pkg holds:
  - the chooser_state_e enum (INIT, RUN);
  - the default constants CHOOSER_IDX_W and CHOOSER_CTR_W;
  - a saturating-increment/decrement function shared with the local and global predictor tables.
- One sub-module, sat_counter_upd: combinational next-value for a CTR_W saturating counter, given a direction and an enable. The table array and the FSM live in tournament_chooser.

## Test plan
- Reset, then count cycles → ready=0 for exactly 4096 cycles (IDX_W=12). A lookup of idx 0x000 during INIT → choice_valid stays 0. After ready, a lookup of 0xABC → choice_use_global=1 (INIT_VAL=2).
- Idx 0x010: three updates with global correct and local wrong, then a lookup → counter=3 and use_global=1. Four updates with local correct, then a lookup → counter=0 and use_global=0. No wrap at either end.
- Idx 0x020: both correct, then both wrong, ×5 → the counter stays 2 and use_global=1 throughout.
- Same cycle: update with local correct on idx 0x030 (counter 2→1) plus a lookup of 0x030 → next cycle choice_use_global=0 (bypass).
- Reset asserted 100 cycles into RUN after training idx 0x040 to 0 → ready drops and the sweep reruns. After ready, a lookup of 0x040 → use_global=1.
- CHOOSER_STATS_EN: 6 updates (4 disagreeing, 1 of which crosses the MSB) → stat_train=4 and stat_flip=1.

Source files
------------

// File: rtl/tournament_pkg.sv
// Shared types, default sizes and the saturating-counter helper for the tournament predictor.
// The tables that use it (chooser, local, global) pick their own counter width up to SAT_MAX_W.
package tournament_pkg;

    typedef enum logic {
        INIT,
        RUN
    } chooser_state_e;

    localparam int CHOOSER_IDX_W = 12;
    localparam int CHOOSER_CTR_W = 2;

    // Widest counter any predictor table may use with sat_step.
    localparam int SAT_MAX_W = 16;
    localparam logic [SAT_MAX_W-1:0] SAT_ONE = SAT_MAX_W'(1);

    // One saturating step towards max_val (up=1) or towards zero (up=0).
    function automatic logic [SAT_MAX_W-1:0] sat_step(
        input logic [SAT_MAX_W-1:0] val,
        input logic [SAT_MAX_W-1:0] max_val,
        input logic                 up
    );
        if (up) begin
            return (val >= max_val) ? max_val : val + SAT_ONE;
        end
        return (val == '0) ? '0 : val - SAT_ONE;
    endfunction

endpackage

// File: rtl/sat_counter_upd.sv
// Combinational next value of a CTR_W-bit saturating counter; passes cur through when en=0.
module sat_counter_upd
    import tournament_pkg::*;
#(
    parameter int CTR_W = CHOOSER_CTR_W
) (
    input  logic [CTR_W-1:0] cur,
    input  logic             en,
    input  logic             up,
    output logic [CTR_W-1:0] nxt
);

    localparam logic [SAT_MAX_W-1:0] CTR_MAX = SAT_MAX_W'((1 << CTR_W) - 1);

    logic [SAT_MAX_W-1:0] stepped;

    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        stepped = sat_step(SAT_MAX_W'(cur), CTR_MAX, up);
        nxt     = en ? CTR_W'(stepped) : cur;
    end

endmodule

// File: rtl/tournament_chooser.sv
// Tournament choice predictor: 2^IDX_W saturating counters selecting global vs local prediction.
// Optional CHOOSER_STATS_EN adds stat_train / stat_flip training counters.
module tournament_chooser
    import tournament_pkg::*;
#(
    parameter int               IDX_W    = CHOOSER_IDX_W,
    parameter int               CTR_W    = CHOOSER_CTR_W,
    parameter logic [CTR_W-1:0] INIT_VAL = CTR_W'(1 << (CTR_W - 1))
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             lookup_valid,
    input  logic [IDX_W-1:0] lookup_idx,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_local_correct,
    input  logic             upd_global_correct,
    output logic             ready,
    output logic             choice_valid,
    output logic             choice_use_global
`ifdef CHOOSER_STATS_EN
    ,
    output logic [31:0]      stat_train,
    output logic [31:0]      stat_flip
`endif
);

    localparam int DEPTH = 1 << IDX_W;

    chooser_state_e   state;
    logic [IDX_W-1:0] sweep_ptr;
    logic [CTR_W-1:0] ctr_mem [DEPTH];

    logic [CTR_W-1:0] upd_cur;
    logic [CTR_W-1:0] upd_nxt;
    logic [CTR_W-1:0] lookup_ctr;
    logic             upd_apply;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [CTR_W-1:0] wr_data;

    assign upd_cur   = ctr_mem[upd_idx];
    assign upd_apply = (state == RUN) && upd_valid && (upd_local_correct != upd_global_correct);

    sat_counter_upd #(
        .CTR_W(CTR_W)
    ) u_upd (
        .cur(upd_cur),
        .en (upd_apply),
        .up (upd_global_correct),
        .nxt(upd_nxt)
    );

    // Single write port shared by the init sweep and training; lookups see a same-cycle update.
    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = upd_idx;
        wr_data = upd_nxt;
        if (state == INIT) begin
            wr_en   = 1'b1;
            wr_idx  = sweep_ptr;
            wr_data = INIT_VAL;
        end else if (upd_apply) begin
            wr_en = 1'b1;
        end
        lookup_ctr = (upd_apply && (upd_idx == lookup_idx)) ? upd_nxt : ctr_mem[lookup_idx];
    end

    // NOTE: the counter array has no reset; the init sweep gives it a defined value instead.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            ctr_mem[wr_idx] <= wr_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= INIT;
            sweep_ptr         <= '0;
            ready             <= 1'b0;
            choice_valid      <= 1'b0;
            choice_use_global <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    sweep_ptr <= sweep_ptr + IDX_W'(1);
                    if (sweep_ptr == '1) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= INIT;
                    ready <= 1'b0;
                end
            endcase
            choice_valid      <= lookup_valid && (state == RUN);
            choice_use_global <= lookup_valid && (state == RUN) && lookup_ctr[CTR_W-1];
        end
    end

`ifdef CHOOSER_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_train <= '0;
            stat_flip  <= '0;
        end else if (upd_apply) begin
            if (stat_train != '1) begin
                stat_train <= stat_train + 32'd1;
            end
            if ((upd_nxt[CTR_W-1] != upd_cur[CTR_W-1]) && (stat_flip != '1)) begin
                stat_flip <= stat_flip + 32'd1;
            end
        end
    end
`endif

endmodule
